float32_2_fix12: RTL and testbench

//  Converts IEEE-754 single-precision floats to signed 32-bit fixed point with 12 fraction bits (Q19.12).

---
 rtl/fixfloat_pkg.sv | 35 +++
 rtl/fix_round_sat.sv | 51 +++++
 rtl/float32_2_fix12.sv | 153 +++++++++++++++
 tb/tb_float32_2_fix12.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixfloat_pkg.sv
// Shared constants and pipeline stage records for the float/fixed-point converters.
package fixfloat_pkg;

    localparam int unsigned FP32_BIAS   = 127;
    localparam int unsigned FP32_MANT_W = 23;
    localparam int unsigned FIX_W       = 32;
    localparam logic [FIX_W-1:0] FIX_MAX = 32'h7FFF_FFFF;
    localparam logic [FIX_W-1:0] FIX_MIN = 32'h8000_0000;

    localparam int unsigned SHIFT_W = 9;
    // Right shifts beyond this leave only sticky information.
    localparam int unsigned GRS_W   = 26;

    typedef struct packed {
        logic                 valid;
        logic                 sign;
        logic                 zero;
        logic                 sat;
        logic                 nan;
        logic [SHIFT_W-1:0]   shift;
        logic [FP32_MANT_W:0] mant;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             zero;
        logic             sat;
        logic             nan;
        logic [FIX_W-1:0] mag;
        logic             guard;
        logic             sticky;
    } s2_t;

endpackage

// File: rtl/fix_round_sat.sv
// Final stage: round-to-nearest-even, negate and saturate into signed fixed point.
// Status flags {ovf, unf, nan} are built only with FLOAT2FIX_STATUS_EN.
module fix_round_sat
    import fixfloat_pkg::*;
(
    input  logic             sign_i,
    input  logic             zero_i,
    input  logic             sat_i,
    input  logic             nan_i,
    input  logic [FIX_W-1:0] mag_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    output logic [FIX_W-1:0] result_o
`ifdef FLOAT2FIX_STATUS_EN
    ,
    output logic [2:0]       flags_o
`endif
);

    logic             round_up;
    logic [FIX_W:0]   rounded;
    logic             ovf;

    assign round_up = guard_i & (sticky_i | mag_i[0]);
    assign rounded  = {1'b0, mag_i} + {{FIX_W{1'b0}}, round_up};
    // A carry reaching the sign bit is treated as overflow, even for the negative extreme.
    assign ovf      = sat_i | rounded[FIX_W] | rounded[FIX_W-1];

    always_comb begin
        result_o = '0;
        if (nan_i || zero_i) begin
            result_o = '0;
        end else if (ovf) begin
            result_o = sign_i ? FIX_MIN : FIX_MAX;
        end else if (sign_i) begin
            result_o = -rounded[FIX_W-1:0];
        end else begin
            result_o = rounded[FIX_W-1:0];
        end
    end

`ifdef FLOAT2FIX_STATUS_EN
    always_comb begin
        flags_o    = '0;
        flags_o[2] = ovf & ~nan_i & ~zero_i;
        flags_o[1] = ~nan_i & ~zero_i & ~ovf & (rounded == '0);
        flags_o[0] = nan_i;
    end
`endif

endmodule

// File: rtl/float32_2_fix12.sv
// AXI4-Stream binary32 -> signed Q(32-FRAC_BITS).FRAC_BITS converter, 3-stage elastic pipeline.
// Optional tuser status flags are enabled by defining FLOAT2FIX_STATUS_EN.
module float32_2_fix12
    import fixfloat_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 12
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s_axis_a_tvalid,
    output logic              s_axis_a_tready,
    input  logic [31:0]       s_axis_a_tdata,
    output logic              m_axis_result_tvalid,
    input  logic              m_axis_result_tready,
    output logic [FIX_W-1:0]  m_axis_result_tdata
`ifdef FLOAT2FIX_STATUS_EN
    ,
    output logic [2:0]        m_axis_result_tuser
`endif
);

    localparam int SHIFT_OFS = FP32_BIAS + FP32_MANT_W - FRAC_BITS;
    localparam int OVF_SH    = FIX_W - 1 - FP32_MANT_W;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic             out_valid_q;
    logic [FIX_W-1:0] out_data_q;
    logic [FIX_W-1:0] rs_data;

    logic out_ready, s2_ready, s1_ready;

    // Each stage may load when empty or when its current contents move on.
    assign out_ready       = ~out_valid_q | m_axis_result_tready;
    assign s2_ready        = ~s2_q.valid | out_ready;
    assign s1_ready        = ~s1_q.valid | s2_ready;
    assign s_axis_a_tready = s1_ready;

    // S1: unpack and classify
    logic [7:0]             in_exp;
    logic [FP32_MANT_W-1:0] in_frac;

    assign in_exp  = s_axis_a_tdata[30:23];
    assign in_frac = s_axis_a_tdata[FP32_MANT_W-1:0];

    always_comb begin
        s1_d       = '0;
        s1_d.valid = s_axis_a_tvalid;
        s1_d.sign  = s_axis_a_tdata[31];
        s1_d.shift = SHIFT_W'(in_exp) - SHIFT_W'(SHIFT_OFS);
        // Denormals keep a zero hidden bit and round away to nothing downstream.
        s1_d.mant  = {in_exp != 8'd0, in_frac};
        s1_d.zero  = (in_exp == 8'd0) && (in_frac == '0);
        s1_d.nan   = (in_exp == 8'hFF) && (in_frac != '0);
        if (in_exp == 8'hFF) begin
            s1_d.sat = (in_frac == '0);
        end else begin
            s1_d.sat = $signed(s1_d.shift) >= $signed(SHIFT_W'(OVF_SH));
        end
    end

    // S2: barrel shift with guard/sticky capture on right shifts
    logic [SHIFT_W-1:0]         rsh;
    logic [4:0]                 rsh_cl;
    logic [FP32_MANT_W+GRS_W:0] wide;

    assign rsh    = -s1_q.shift;
    assign rsh_cl = (rsh > SHIFT_W'(GRS_W)) ? 5'(GRS_W) : rsh[4:0];
    assign wide   = {s1_q.mant, {GRS_W{1'b0}}} >> rsh_cl;

    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.sign  = s1_q.sign;
        s2_d.zero  = s1_q.zero;
        s2_d.sat   = s1_q.sat;
        s2_d.nan   = s1_q.nan;
        if (!s1_q.shift[SHIFT_W-1]) begin
            // Only shifts below the overflow threshold matter; larger ones are saturated.
            s2_d.mag = {{(FIX_W-FP32_MANT_W-1){1'b0}}, s1_q.mant} << s1_q.shift[2:0];
        end else begin
            s2_d.mag    = {{(FIX_W-FP32_MANT_W-1){1'b0}}, wide[FP32_MANT_W+GRS_W:GRS_W]};
            s2_d.guard  = wide[GRS_W-1];
            s2_d.sticky = |wide[GRS_W-2:0];
        end
    end

    // S3: round, negate, saturate
`ifdef FLOAT2FIX_STATUS_EN
    logic [2:0] rs_flags;
    logic [2:0] out_user_q;

    fix_round_sat u_round_sat (
        .sign_i   (s2_q.sign),
        .zero_i   (s2_q.zero),
        .sat_i    (s2_q.sat),
        .nan_i    (s2_q.nan),
        .mag_i    (s2_q.mag),
        .guard_i  (s2_q.guard),
        .sticky_i (s2_q.sticky),
        .result_o (rs_data),
        .flags_o  (rs_flags)
    );

    assign m_axis_result_tuser = out_user_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_user_q <= '0;
        end else if (out_ready && s2_q.valid) begin
            out_user_q <= rs_flags;
        end
    end
`else
    fix_round_sat u_round_sat (
        .sign_i   (s2_q.sign),
        .zero_i   (s2_q.zero),
        .sat_i    (s2_q.sat),
        .nan_i    (s2_q.nan),
        .mag_i    (s2_q.mag),
        .guard_i  (s2_q.guard),
        .sticky_i (s2_q.sticky),
        .result_o (rs_data)
    );
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (s1_ready) begin
                s1_q <= s1_d;
            end
            if (s2_ready) begin
                s2_q <= s2_d;
            end
            if (out_ready) begin
                out_valid_q <= s2_q.valid;
                if (s2_q.valid) begin
                    out_data_q <= rs_data;
                end
            end
        end
    end

    assign m_axis_result_tvalid = out_valid_q;
    assign m_axis_result_tdata  = out_data_q;

endmodule

// File: tb/tb_float32_2_fix12.sv
// Self-checking bench for float32_2_fix12: directed vectors, latency/reset sequences,
// and randomized traffic with backpressure checked against an arithmetic reference model.
module tb_float32_2_fix12;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  user;
    } res_t;

    typedef struct {
        logic [31:0] din;
        res_t        exp;
    } vec_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] m_tdata;
`ifdef FLOAT2FIX_STATUS_EN
    logic [2:0]  m_tuser;
`endif

    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    res_t exp_q[$];
    res_t mon_exp;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    float32_2_fix12 dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_a_tvalid      (s_tvalid),
        .s_axis_a_tready      (s_tready),
        .s_axis_a_tdata       (s_tdata),
        .m_axis_result_tvalid (m_tvalid),
        .m_axis_result_tready (m_tready),
        .m_axis_result_tdata  (m_tdata)
`ifdef FLOAT2FIX_STATUS_EN
        ,
        .m_axis_result_tuser  (m_tuser)
`endif
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        #1;
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Value-level model: fixed = M * 2^(e-150) * 2^12, ties to even by remainder comparison.
    function automatic res_t model(input logic [31:0] f);
        res_t r;
        logic s;
        int e, p, k;
        longint unsigned m, q, rem, half;
        bit big;
        r = '0;
        s = f[31];
        e = int'(f[30:23]);
        if (e == 255 && f[22:0] != 0) begin
            r.user = 3'b001;
            return r;
        end
        if (e == 255) begin
            r.data = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r.user = 3'b100;
            return r;
        end
        if (f[30:0] == 0) return r;
        m = (e == 0) ? longint'(f[22:0]) : (longint'(f[22:0]) | (64'd1 << 23));
        p = ((e == 0) ? 1 : e) - 150 + 12;
        big = 1'b0;
        q = 0;
        if (p >= 0) begin
            if (p >= 32) big = 1'b1;
            else q = m << p;
        end else begin
            k = -p;
            if (k < 40) begin
                q = m >> k;
                rem = m - (q << k);
                half = 64'd1 << (k - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
            end
        end
        if (big || q > 64'h7FFF_FFFF) begin
            r.data = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r.user = 3'b100;
        end else begin
            r.data = s ? 32'(-q) : 32'(q);
            r.user = (q == 0) ? 3'b010 : 3'b000;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0]  e;
        logic [22:0] fr;
        case ($urandom_range(0, 15))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'($urandom_range(0, 255));
            default: e = 8'($urandom_range(100, 150));
        endcase
        fr = 23'($urandom);
        if ($urandom_range(0, 3) == 0) fr = fr & 23'h7FFF00;
        return {1'($urandom), e, fr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge aclk) begin
        if (!areset) begin
            if (prev_stall) begin
                checks++;
                if (!m_tvalid || m_tdata !== prev_data) begin
                    errors++;
                    $display("FAIL hold: tvalid=%b tdata=%h, expected tvalid=1 tdata=%h",
                             m_tvalid, m_tdata, prev_data);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: tdata=%h, expected no beat", m_tdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (m_tdata !== mon_exp.data) begin
                        errors++;
                        $display("FAIL tdata: got %h, expected %h", m_tdata, mon_exp.data);
                    end
`ifdef FLOAT2FIX_STATUS_EN
                    checks++;
                    if (m_tuser !== mon_exp.user) begin
                        errors++;
                        $display("FAIL tuser: got %b, expected %b (tdata %h)",
                                 m_tuser, mon_exp.user, mon_exp.data);
                    end
`endif
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Leaves s_tvalid high so consecutive calls stream back to back.
    task automatic send(input logic [31:0] d, input res_t e, input bit track);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        @(negedge aclk);
        while (!s_tready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        if (!s_tready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tready=%b, expected 1 within 200 cycles", s_tready);
        end else if (track) begin
            exp_q.push_back(e);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        s_tvalid = 1'b0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge aclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge aclk);
        #1;
    endtask

    // Called just after the accepting edge; the result must appear on the third edge.
    task automatic latency_check(input string tag);
        s_tvalid = 1'b0;
        chk({tag, "_tvalid_edge1"}, 32'(m_tvalid), 32'd0);
        @(posedge aclk);
        #1;
        chk({tag, "_tvalid_edge2"}, 32'(m_tvalid), 32'd0);
        @(posedge aclk);
        #1;
        chk({tag, "_tvalid_edge3"}, 32'(m_tvalid), 32'd1);
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{32'h3F80_0000, '{32'h0000_1000, 3'b000}};
        vecs[1]  = '{32'hBFC0_0000, '{32'hFFFF_E800, 3'b000}};
        vecs[2]  = '{32'h401C_4000, '{32'h0000_2710, 3'b000}};
        vecs[3]  = '{32'hC01C_4000, '{32'hFFFF_D8F0, 3'b000}};
        vecs[4]  = '{32'h3900_0000, '{32'h0000_0000, 3'b010}};
        vecs[5]  = '{32'h39C0_0000, '{32'h0000_0002, 3'b000}};
        vecs[6]  = '{32'h4974_2400, '{32'h7FFF_FFFF, 3'b100}};
        vecs[7]  = '{32'hC974_2400, '{32'h8000_0000, 3'b100}};
        vecs[8]  = '{32'h7FC0_0000, '{32'h0000_0000, 3'b001}};
        vecs[9]  = '{32'h7F80_0000, '{32'h7FFF_FFFF, 3'b100}};
        vecs[10] = '{32'hFF80_0000, '{32'h8000_0000, 3'b100}};
        vecs[11] = '{32'h8000_0000, '{32'h0000_0000, 3'b000}};
        vecs[12] = '{32'h0000_0001, '{32'h0000_0000, 3'b010}};
        vecs[13] = '{32'h3A00_0000, '{32'h0000_0002, 3'b000}};
        vecs[14] = '{32'h48FF_FFFF, '{32'h7FFF_FF80, 3'b000}};
        vecs[15] = '{32'hC8FF_FFFF, '{32'h8000_0080, 3'b000}};
        vecs[16] = '{32'h4900_0000, '{32'h7FFF_FFFF, 3'b100}};
        vecs[17] = '{32'hC900_0000, '{32'h8000_0000, 3'b100}};
        vecs[18] = '{32'h0000_0000, '{32'h0000_0000, 3'b000}};

        repeat (3) @(posedge aclk);
        #1;
        chk("reset_tvalid", 32'(m_tvalid), 32'd0);
        chk("reset_tdata", m_tdata, 32'd0);
        areset = 1'b0;
        chk("reset_s_tready", 32'(s_tready), 32'd1);

        send(32'h3F80_0000, model(32'h3F80_0000), 1'b1);
        latency_check("lat_pos");
        drain();
        send(32'hBFC0_0000, model(32'hBFC0_0000), 1'b1);
        latency_check("lat_neg");
        drain();

        foreach (vecs[i]) send(vecs[i].din, vecs[i].exp, 1'b1);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] f = rand_float();
            send(f, model(f), 1'b1);
        end
        for (int i = 0; i < 300; i++) begin
            logic [31:0] f = rand_float();
            if ($urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            send(f, model(f), 1'b1);
        end
        drain();
        rand_ready = 1'b0;
        @(posedge aclk);
        #1;

        send(32'h3F80_0000, model(32'h3F80_0000), 1'b0);
        send(32'h4974_2400, model(32'h4974_2400), 1'b0);
        s_tvalid = 1'b0;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        chk("post_reset_s_tready", 32'(s_tready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("post_reset_no_beat", 32'(m_tvalid), 32'd0);
            @(posedge aclk);
            #1;
        end
        send(32'hC01C_4000, model(32'hC01C_4000), 1'b1);
        latency_check("lat_after_reset");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
